// File: rtl/block_serial_subtractor_if.sv
// Operand/result bundle for block_serial_subtractor.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer holds valid and its payload until that edge. ready may
// depend on state but never on valid. The input side uses in_valid/in_ready
// with payload A, B and Bin. The output side uses out_valid/out_ready with
// payload D, Bout and, when built with it, ovf.
// Optional feature macro: SUB_OVERFLOW_EN adds the signed-overflow flag ovf.
interface block_serial_subtractor_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  Bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] D;
    logic                  Bout;
`ifdef SUB_OVERFLOW_EN
    logic                  ovf;
`endif

    // Producer of operands and consumer of results (e.g. a testbench).
    modport master (
        output in_valid, A, B, Bin, out_ready,
`ifdef SUB_OVERFLOW_EN
        input  ovf,
`endif
        input  in_ready, out_valid, D, Bout
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, A, B, Bin, out_ready,
`ifdef SUB_OVERFLOW_EN
        output ovf,
`endif
        output in_ready, out_valid, D, Bout
    );
endinterface

// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor that computes D = A - B - Bin one BLOCK_SIZE-bit slice
// per cycle, from least to most significant, with a registered borrow chain.
// Optional feature macro: SUB_OVERFLOW_EN adds the registered signed-overflow
// output ovf.
// dbg_state exposes the FSM state: 0 = IDLE, 1 = BUSY, 2 = DONE.
module block_serial_subtractor #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    block_serial_subtractor_if.slave      bus,
    output logic [1:0]                    dbg_state
);
    localparam int STAGES = DATA_WIDTH / BLOCK_SIZE;
    localparam int CNT_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(STAGES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    borrow_q;
    logic [DATA_WIDTH-1:0]   d_q;
    logic                    bout_q;
    logic                    out_valid_q;
`ifdef SUB_OVERFLOW_EN
    logic                    ovf_q;
`endif

    logic [BLOCK_SIZE-1:0]   a_blk;
    logic [BLOCK_SIZE-1:0]   b_blk;
    logic [BLOCK_SIZE:0]     blk_res;
    logic [DATA_WIDTH-1:0]   d_next;
    int                      offset;

    // Select slice cnt of the latched operands and subtract it with the
    // running borrow. blk_res[BLOCK_SIZE] is the borrow out of this slice.
    always_comb begin
        offset  = int'(cnt) * BLOCK_SIZE;
        a_blk   = BLOCK_SIZE'(a_q >> offset);
        b_blk   = BLOCK_SIZE'(b_q >> offset);
        blk_res = {1'b0, a_blk} - {1'b0, b_blk} - {{BLOCK_SIZE{1'b0}}, borrow_q};
        d_next  = (d_q & ~({{(DATA_WIDTH-BLOCK_SIZE){1'b0}}, {BLOCK_SIZE{1'b1}}} << offset))
                | ({{(DATA_WIDTH-BLOCK_SIZE){1'b0}}, blk_res[BLOCK_SIZE-1:0]} << offset);
    end

    // Control FSM with datapath registers. Loading Bin into borrow_q at
    // accept makes it the borrow-in for slice 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        borrow_q <= bus.Bin;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    d_q      <= d_next;
                    borrow_q <= blk_res[BLOCK_SIZE];
                    if (cnt == LAST_BLK) begin
                        bout_q      <= blk_res[BLOCK_SIZE];
                        out_valid_q <= 1'b1;
                        state       <= DONE;
`ifdef SUB_OVERFLOW_EN
                        // Overflow occurs when the operand signs differ and
                        // the result sign differs from the minuend sign.
                        ovf_q <= (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1])
                               & (blk_res[BLOCK_SIZE-1] ^ a_q[DATA_WIDTH-1]);
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Drive the outputs from the registers. in_ready also drops while reset
    // is held.
    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.out_valid = out_valid_q;
        bus.D         = d_q;
        bus.Bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
        bus.ovf       = ovf_q;
`endif
        dbg_state     = state;
    end
endmodule

// File: tb/tb_block_serial_subtractor.sv
// Testbench for block_serial_subtractor (DATA_WIDTH=32, BLOCK_SIZE=16).
// Optional feature macro: SUB_OVERFLOW_EN also checks ovf.
module tb_block_serial_subtractor;
    localparam int DW     = 32;
    localparam int BS     = 16;
    localparam int STAGES = DW / BS;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_serial_subtractor_if #(.DATA_WIDTH(DW)) bus ();
    logic [1:0] dbg_state;

    block_serial_subtractor #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard: {Bout, D} expected per accepted operation.
    logic [DW:0] exp_q[$];
`ifdef SUB_OVERFLOW_EN
    logic        exp_ovf_q[$];
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [DW:0] ref_sub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic bin);
        logic [DW-1:0] d;
        logic          bout;
        d    = a - b - DW'(bin);
        bout = (longint'(a) < longint'(b) + longint'(bin));
        return {bout, d};
    endfunction

    function automatic logic ref_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic bin);
        longint s;
        longint lim;
        s   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        lim = longint'(1) <<< (DW - 1);
        return (s > lim - 1) || (s < -lim);
    endfunction

    // Driver plus checks for one full operation. hold is the number of
    // extra cycles out_ready stays low while the result is presented.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bin,
                          input int hold, input string tag);
        int          n;
        logic [DW:0] exp;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        exp_q.push_back(ref_sub(a, b, bin));
`ifdef SUB_OVERFLOW_EN
        exp_ovf_q.push_back(ref_ovf(a, b, bin));
`endif
        step();
        // Accepting edge is behind us; anything driven now must be ignored.
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.A         = $urandom;
            bus.B         = $urandom;
            bus.Bin       = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        bus.out_ready = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(STAGES));
        exp = exp_q.pop_front();
        check({tag, "_D"}, 64'(bus.D), 64'(exp[DW-1:0]));
        check({tag, "_Bout"}, 64'(bus.Bout), 64'(exp[DW]));
        check({tag, "_busy_in_ready"}, 64'(bus.in_ready), 64'(0));
`ifdef SUB_OVERFLOW_EN
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf_q.pop_front()));
`endif
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.A        = $urandom;
            step();
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
            check({tag, "_hold_D"}, 64'(bus.D), 64'(exp[DW-1:0]));
            check({tag, "_hold_Bout"}, 64'(bus.Bout), 64'(exp[DW]));
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'(0));
        end
        // Consume while offering a new operand; it must not be taken.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "_consumed_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_D", 64'(bus.D), 64'(0));
        check("rst_Bout", 64'(bus.Bout), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed cases.
        run_op(32'h0001_0000, 32'h0000_0001, 1'b0, 0, "xblk");
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1, "under");
        run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 3, "bin_eq");
        run_op(32'h0000_0007, 32'h0000_0002, 1'b1, 0, "bin_pos");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "all_ones");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, "ovf_set");
        run_op(32'h0000_0003, 32'h0000_0001, 1'b0, 0, "ovf_clr");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "ovf_pos");

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        // Reset one cycle after accept aborts the operation.
        bus.in_valid = 1'b1;
        bus.A        = 32'h0000_FFFF;
        bus.B        = 32'h0000_0001;
        bus.Bin      = 1'b0;
        step();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'(0));
        check("abort_D", 64'(bus.D), 64'(0));
        check("abort_Bout", 64'(bus.Bout), 64'(0));
        check("abort_in_ready", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_quiet", 64'(bus.out_valid), 64'(0));
        end

        // Normal operation resumes after the abort.
        run_op(32'h1234_5678, 32'h0000_5679, 1'b0, 1, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
